cp0_exc_unit: RTL and testbench
===============================

// Module: cp0_exc_unit
// PURPOSE
// Coprocessor-0 exception/interrupt unit, committed at the M stage. Consumes the F-stage branch-delay flag
// F_BD produced by the D-stage decode, pipelines it F->D->E->M alongside the instruction, and on an
// exception or interrupt records EPC/Cause.BD and redirects fetch to the handler.
// Also holds SR/Cause/EPC/PRId for mfc0/mtc0 and returns EPC on eret.
// PARAMETERS
// HANDLER_ADDR  32'h0000_4180  fetch address driven on exc_req
// PRID_VAL      32'h2023_1205  read-only value of PRId (reg 15)
// PORTS
// clk          in   1   system clock, rising edge
// reset        in   1   asynchronous, active-low reset
// F_BD         in   1   1 = instruction now in F sits in a branch delay slot
// stall        in   1   freeze F/D and D/E registers; bubble enters E
// pc_m         in   32  PC of instruction in M
// exc_code_m   in   5   exception code detected for M instr (0 = none)
// hw_int       in   6   external interrupt lines, level-sensitive
// cp0_addr     in   5   mfc0/mtc0 register number
// cp0_we       in   1   mtc0 in M
// cp0_wdata    in   32  mtc0 data
// eret_m       in   1   eret in M
// cp0_rdata    out  32  mfc0 data, combinational from cp0_addr
// exc_req      out  1   take exception/interrupt this cycle (flush F..M)
// epc_out      out  32  current EPC (eret target)
// handler_pc   out  32  = HANDLER_ADDR
// BEHAVIOUR
// - Reset (async, reset==0): SR=0, Cause=0, EPC=0, bd_d=bd_e=bd_m=0; exc_req=0; epc_out=0.
// - SR(12): IM=[15:10], EXL=[1], IE=[0]; other bits read 0, writes ignored.
// - Cause(13): BD=[31], IP=[15:10], ExcCode=[6:2]; read-only to mtc0. EPC(14); PRId(15)=PRID_VAL.
// - Unmapped cp0_addr reads 0; mtc0 to unmapped/PRId ignored.
// - BD pipeline per posedge: if exc_req: bd_d=bd_e=bd_m=0.
//   elif stall: bd_d holds, bd_e<=bd_d (bubble inherits BD), bd_m<=bd_e.
//   else bd_d<=F_BD, bd_e<=bd_d, bd_m<=bd_e.
// - int_req = |(hw_int & SR.IM) & SR.IE & ~SR.EXL. exc_hit = (exc_code_m!=0) & ~SR.EXL.
// - exc_req = int_req | exc_hit, combinational, same cycle; interrupt wins when both.
// - On exc_req at posedge: SR.EXL<=1; Cause.ExcCode<= int_req ? 0 : exc_code_m; Cause.BD<=bd_m;
//   EPC <= bd_m ? pc_m-4 : pc_m (32-bit wrap on subtract); mtc0 in that cycle is discarded.
// - Cause.IP <= hw_int every cycle, regardless of EXL/IE/exc_req.
// - mtc0 (cp0_we & ~exc_req): SR/EPC written; EPC write forces bits[1:0]=0.
// - eret_m & ~exc_req: SR.EXL<=0 at posedge. epc_out = EPC register (no bypass from same-cycle mtc0).
// - eret_m with exc_req same cycle: exception wins; EXL stays 1.
// - Reset mid-operation clears pipeline BD flags; no pending exception survives reset.
// - Latency: request 0 cycles (comb); register updates visible next cycle.
// TESTING
// - Reset: drive reset=0 mid-run with SR=0x0000FC03 -> all regs 0, exc_req=0 immediately.
// - Delay-slot int: F_BD=1 one cycle, no stall, SR=0x00000401, hw_int=1 when bd_m=1, pc_m=0x3008
//   -> exc_req=1; next: EPC=0x3004, Cause.BD=1, ExcCode=0, EXL=1.
// - Stall bubble: F_BD=1 then stall 2 cycles -> bd_e/bd_m stay 1 through the bubbles; exc_code_m=12
//   on the bubble, pc_m=0x3010 -> EPC=0x300C, ExcCode=12, BD=1.
// - Masking: EXL=1 or IE=0 or IM=0 with hw_int=6'h3F -> exc_req=0, Cause.IP=0x3F reflected.
// - Simultaneous: int_req and exc_code_m=4 -> ExcCode=0; mtc0 EPC=0x1234 same cycle discarded.
// - eret: EXL=1, EPC=0x3050, eret_m=1 -> epc_out=0x3050, EXL=0 next cycle; mtc0 EPC=0x3007 reads 0x3004.

Source files
------------

// File: rtl/cp0_exc_unit_if.sv
// Pipeline-to-CP0 bundle: M-stage commit info, mtc0/mfc0 access,
// and the exception redirect returned to fetch.
interface cp0_exc_unit_if;
    logic        F_BD;
    logic        stall;
    logic [31:0] pc_m;
    logic [4:0]  exc_code_m;
    logic [5:0]  hw_int;
    logic [4:0]  cp0_addr;
    logic        cp0_we;
    logic [31:0] cp0_wdata;
    logic        eret_m;
    logic [31:0] cp0_rdata;
    logic        exc_req;
    logic [31:0] epc_out;
    logic [31:0] handler_pc;

    modport master (
        output F_BD, stall, pc_m, exc_code_m, hw_int,
        output cp0_addr, cp0_we, cp0_wdata, eret_m,
        input  cp0_rdata, exc_req, epc_out, handler_pc
    );

    modport slave (
        input  F_BD, stall, pc_m, exc_code_m, hw_int,
        input  cp0_addr, cp0_we, cp0_wdata, eret_m,
        output cp0_rdata, exc_req, epc_out, handler_pc
    );
endinterface

// File: rtl/cp0_exc_unit.sv
// CP0 exception/interrupt unit committed at M: SR/Cause/EPC/PRId,
// branch-delay flag pipeline F->D->E->M, and fetch redirect.
module cp0_exc_unit #(
    parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180,
    parameter logic [31:0] PRID_VAL     = 32'h2023_1205
) (
    input  logic           clk,
    input  logic           reset,
    cp0_exc_unit_if.slave  cp0
);

    logic [5:0]  im_q;
    logic        exl_q;
    logic        ie_q;
    logic        cbd_q;
    logic [5:0]  ip_q;
    logic [4:0]  exccode_q;
    logic [31:0] epc_q;
    logic        bd_id_q;
    logic        bd_ex_q;
    logic        bd_m_q;

    logic        int_req;
    logic        exc_hit;
    logic        exc_req;
    logic [31:0] epc_d;

    assign int_req = (|(cp0.hw_int & im_q)) & ie_q & ~exl_q;
    assign exc_hit = (cp0.exc_code_m != 5'd0) & ~exl_q;
    assign exc_req = int_req | exc_hit;

    // A delay-slot instruction restarts at its branch.
    assign epc_d = bd_m_q ? (cp0.pc_m - 32'd4) : cp0.pc_m;

    assign cp0.exc_req    = exc_req;
    assign cp0.epc_out    = epc_q;
    assign cp0.handler_pc = HANDLER_ADDR;

    always_comb begin
        cp0.cp0_rdata = 32'd0;
        unique case (cp0.cp0_addr)
            5'd12: cp0.cp0_rdata = {16'd0, im_q, 8'd0, exl_q, ie_q};
            5'd13: cp0.cp0_rdata = {cbd_q, 15'd0, ip_q, 3'd0,
                                    exccode_q, 2'd0};
            5'd14: cp0.cp0_rdata = epc_q;
            5'd15: cp0.cp0_rdata = PRID_VAL;
            default: cp0.cp0_rdata = 32'd0;
        endcase
    end

    // Stalled D keeps its flag; the bubble entering E inherits it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bd_id_q <= 1'b0;
            bd_ex_q <= 1'b0;
            bd_m_q  <= 1'b0;
        end else if (exc_req) begin
            bd_id_q <= 1'b0;
            bd_ex_q <= 1'b0;
            bd_m_q  <= 1'b0;
        end else begin
            if (!cp0.stall) begin
                bd_id_q <= cp0.F_BD;
            end
            bd_ex_q <= bd_id_q;
            bd_m_q  <= bd_ex_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            im_q      <= 6'd0;
            exl_q     <= 1'b0;
            ie_q      <= 1'b0;
            cbd_q     <= 1'b0;
            ip_q      <= 6'd0;
            exccode_q <= 5'd0;
            epc_q     <= 32'd0;
        end else begin
            ip_q <= cp0.hw_int;
            if (exc_req) begin
                exl_q     <= 1'b1;
                exccode_q <= int_req ? 5'd0 : cp0.exc_code_m;
                cbd_q     <= bd_m_q;
                epc_q     <= epc_d;
            end else begin
                if (cp0.cp0_we && cp0.cp0_addr == 5'd12) begin
                    im_q  <= cp0.cp0_wdata[15:10];
                    exl_q <= cp0.cp0_wdata[1];
                    ie_q  <= cp0.cp0_wdata[0];
                end
                if (cp0.cp0_we && cp0.cp0_addr == 5'd14) begin
                    epc_q <= {cp0.cp0_wdata[31:2], 2'b00};
                end
                if (cp0.eret_m) begin
                    exl_q <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_cp0_exc_unit.sv
// Directed bench for cp0_exc_unit: reset, delay-slot EPC, stall bubbles,
// masking, interrupt/exception priority, mtc0 and eret.
module tb_cp0_exc_unit;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    cp0_exc_unit_if bus ();

    cp0_exc_unit dut (
        .clk   (clk),
        .reset (reset),
        .cp0   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic rd(input logic [4:0] a, input logic [31:0] exp,
                      input string tag);
        bus.cp0_addr = a;
        #1;
        chk(tag, bus.cp0_rdata, exp);
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        bus.cp0_addr  = a;
        bus.cp0_wdata = d;
        bus.cp0_we    = 1'b1;
        tick();
        bus.cp0_we    = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset          = 1'b0;
        bus.F_BD       = 1'b0;
        bus.stall      = 1'b0;
        bus.pc_m       = 32'd0;
        bus.exc_code_m = 5'd0;
        bus.hw_int     = 6'd0;
        bus.cp0_addr   = 5'd0;
        bus.cp0_we     = 1'b0;
        bus.cp0_wdata  = 32'd0;
        bus.eret_m     = 1'b0;
        tick();
        tick();

        chk("rst_exc_req", {31'd0, bus.exc_req}, 32'd0);
        chk("rst_epc_out", bus.epc_out, 32'd0);
        chk("handler_pc", bus.handler_pc, 32'h0000_4180);
        rd(5'd12, 32'd0, "rst_sr");
        rd(5'd13, 32'd0, "rst_cause");
        rd(5'd15, 32'h2023_1205, "prid");

        reset = 1'b1;
        tick();

        // Load state, then reset mid-run
        wr(5'd12, 32'hFFFF_FC03);
        rd(5'd12, 32'h0000_FC03, "sr_write_mask");
        wr(5'd14, 32'h0000_3007);
        chk("mtc0_epc_align", bus.epc_out, 32'h0000_3004);
        bus.hw_int = 6'h3F;
        #1;
        chk("mask_exl", {31'd0, bus.exc_req}, 32'd0);
        tick();
        rd(5'd13, 32'h0000_FC00, "ip_under_exl");
        reset = 1'b0;
        #1;
        chk("midrst_exc_req", {31'd0, bus.exc_req}, 32'd0);
        rd(5'd12, 32'd0, "midrst_sr");
        rd(5'd13, 32'd0, "midrst_cause");
        rd(5'd14, 32'd0, "midrst_epc");
        bus.hw_int = 6'd0;
        tick();
        reset = 1'b1;
        tick();

        // Interrupt on a delay-slot instruction
        wr(5'd12, 32'h0000_0401);
        bus.F_BD = 1'b1;
        tick();
        bus.F_BD = 1'b0;
        tick();
        tick();
        bus.hw_int = 6'h01;
        bus.pc_m   = 32'h0000_3008;
        #1;
        chk("ds_int_req", {31'd0, bus.exc_req}, 32'd1);
        tick();
        bus.hw_int = 6'd0;
        rd(5'd14, 32'h0000_3004, "ds_epc");
        rd(5'd13, 32'h8000_0400, "ds_cause");
        rd(5'd12, 32'h0000_0403, "ds_sr_exl");

        // eret back to EPC
        wr(5'd14, 32'h0000_3050);
        chk("eret_epc_out", bus.epc_out, 32'h0000_3050);
        bus.eret_m = 1'b1;
        tick();
        bus.eret_m = 1'b0;
        rd(5'd12, 32'h0000_0401, "eret_exl_clr");

        // Delay-slot flag carried through stall bubbles
        bus.F_BD = 1'b1;
        tick();
        bus.F_BD  = 1'b0;
        bus.stall = 1'b1;
        tick();
        tick();
        bus.exc_code_m = 5'd12;
        bus.pc_m       = 32'h0000_3010;
        #1;
        chk("bubble_exc_req", {31'd0, bus.exc_req}, 32'd1);
        tick();
        bus.exc_code_m = 5'd0;
        bus.stall      = 1'b0;
        rd(5'd14, 32'h0000_300C, "bubble_epc");
        rd(5'd13, 32'h8000_0030, "bubble_cause");

        // IE=0 and IM=0 masking
        wr(5'd12, 32'h0000_FC00);
        bus.hw_int = 6'h3F;
        #1;
        chk("mask_ie", {31'd0, bus.exc_req}, 32'd0);
        wr(5'd12, 32'h0000_0001);
        #1;
        chk("mask_im", {31'd0, bus.exc_req}, 32'd0);
        rd(5'd13, 32'h8000_FC30, "ip_reflect");

        // Interrupt and exception together, with a dropped mtc0
        wr(5'd12, 32'h0000_FC01);
        bus.exc_code_m = 5'd4;
        bus.pc_m       = 32'h0000_3020;
        bus.cp0_addr   = 5'd14;
        bus.cp0_wdata  = 32'h0000_1234;
        bus.cp0_we     = 1'b1;
        #1;
        chk("sim_exc_req", {31'd0, bus.exc_req}, 32'd1);
        tick();
        bus.cp0_we     = 1'b0;
        bus.exc_code_m = 5'd0;
        bus.hw_int     = 6'd0;
        rd(5'd14, 32'h0000_3020, "sim_epc");
        rd(5'd13, 32'h0000_FC00, "sim_cause");
        rd(5'd12, 32'h0000_FC03, "sim_sr");

        // Exception beats eret in the same cycle
        wr(5'd12, 32'h0000_FC01);
        bus.exc_code_m = 5'd8;
        bus.pc_m       = 32'h0000_3040;
        bus.eret_m     = 1'b1;
        tick();
        bus.eret_m     = 1'b0;
        bus.exc_code_m = 5'd0;
        rd(5'd12, 32'h0000_FC03, "eret_vs_exc_sr");
        rd(5'd13, 32'h0000_0020, "eret_vs_exc_cause");

        // Read-only and unmapped registers
        wr(5'd15, 32'hDEAD_BEEF);
        rd(5'd15, 32'h2023_1205, "prid_ro");
        wr(5'd5, 32'hDEAD_BEEF);
        rd(5'd5, 32'd0, "unmapped");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
